// File: rtl/pipe_ctrl.sv
// pipe_ctrl: pipeline sequencer for the 5-stage core.
// Drives stall/flush controls, owns the fetch PC redirect and sequences
// trap-entry settle bubbles and multi-cycle divide waits (with timeout).
module pipe_ctrl #(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned TRAP_LAT = 2,
  parameter int unsigned DIV_MAX  = 40
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            trap_req,
  input  logic [XLEN-1:0] trap_vec,
  input  logic            mret_req,
  input  logic [XLEN-1:0] mepc,
  input  logic            ex_bj_flag,
  input  logic [XLEN-1:0] ex_bj_addr,
  input  logic            ex_div_start,
  input  logic            div_done,
  input  logic            ex_is_load,
  input  logic [4:0]      ex_rd,
  input  logic [4:0]      id_rs1,
  input  logic [4:0]      id_rs2,
  input  logic            id_rs1_used,
  input  logic            id_rs2_used,
  output logic            pipe_stall,
  output logic            if_flush,
  output logic            id_flush,
  output logic            ex_flush,
  output logic            redirect_valid,
  output logic [XLEN-1:0] redirect_pc,
  output logic            div_kill,
  output logic            div_timeout,
  output logic [1:0]      ctrl_state
);

  localparam int unsigned CNT_W  = 4;
  localparam int unsigned DCNT_W = 8;

  // Trap settle reload value and the last divide-wait count before timeout
  localparam logic [CNT_W-1:0]  TRAP_LAT_C = CNT_W'(TRAP_LAT);
  localparam logic [DCNT_W-1:0] DIV_LAST   = DCNT_W'(DIV_MAX - 2);
  localparam logic [DCNT_W-1:0] DCNT_SAT   = '1;

  typedef enum logic [1:0] {
    S_RUN       = 2'd0,
    S_TRAP_WAIT = 2'd1,
    S_DIV_BUSY  = 2'd2
  } state_t;

  state_t            state, state_nx;
  logic [CNT_W-1:0]  cnt, cnt_nx;
  logic [DCNT_W-1:0] dcnt, dcnt_nx;
  logic              redir_nx;
  logic [XLEN-1:0]   redir_pc_nx;
  logic              kill_nx;
  logic              tmo_nx;
  logic              luh;

  // Load-use hazard: loaded register is read by the instruction in ID
  assign luh = ex_is_load && (ex_rd != 5'd0) &&
               ((id_rs1_used && (id_rs1 == ex_rd)) ||
                (id_rs2_used && (id_rs2 == ex_rd)));

  assign ctrl_state = state;

  // State, counters and registered outputs; reset is synchronous
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state          <= S_RUN;
      cnt            <= '0;
      dcnt           <= '0;
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
      div_kill       <= 1'b0;
      div_timeout    <= 1'b0;
    end else begin
      state          <= state_nx;
      cnt            <= cnt_nx;
      dcnt           <= dcnt_nx;
      redirect_valid <= redir_nx;
      redirect_pc    <= redir_pc_nx;
      div_kill       <= kill_nx;
      div_timeout    <= tmo_nx;
    end
  end

  // Next-state, arbitration and same-cycle stall/flush controls
  always_comb begin
    state_nx    = state;
    cnt_nx      = cnt;
    dcnt_nx     = dcnt;
    redir_nx    = 1'b0;
    redir_pc_nx = redirect_pc;
    kill_nx     = 1'b0;
    tmo_nx      = 1'b0;
    pipe_stall  = 1'b0;
    if_flush    = 1'b0;
    id_flush    = 1'b0;
    ex_flush    = 1'b0;

    unique case (state)
      S_RUN: begin
        if (trap_req) begin
          if_flush    = 1'b1;
          id_flush    = 1'b1;
          ex_flush    = 1'b1;
          redir_nx    = 1'b1;
          redir_pc_nx = trap_vec;
          state_nx    = S_TRAP_WAIT;
          cnt_nx      = TRAP_LAT_C;
        end else if (mret_req) begin
          if_flush    = 1'b1;
          id_flush    = 1'b1;
          redir_nx    = 1'b1;
          redir_pc_nx = mepc;
        end else if (ex_bj_flag) begin
          if_flush    = 1'b1;
          id_flush    = 1'b1;
          redir_nx    = 1'b1;
          redir_pc_nx = ex_bj_addr;
        end else if (ex_div_start) begin
          pipe_stall  = 1'b1;
          state_nx    = S_DIV_BUSY;
          dcnt_nx     = '0;
        end else if (luh) begin
          pipe_stall  = 1'b1;
          id_flush    = 1'b1;
        end
      end

      S_TRAP_WAIT: begin
        pipe_stall = 1'b1;
        if (trap_req) begin
          // Nested trap wins and restarts the settle window
          if_flush    = 1'b1;
          id_flush    = 1'b1;
          ex_flush    = 1'b1;
          redir_nx    = 1'b1;
          redir_pc_nx = trap_vec;
          cnt_nx      = TRAP_LAT_C;
        end else if (cnt <= CNT_W'(1)) begin
          state_nx = S_RUN;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt - CNT_W'(1);
        end
      end

      S_DIV_BUSY: begin
        if (trap_req) begin
          // Interrupt aborts the divide; any same-cycle result is discarded
          if_flush    = 1'b1;
          id_flush    = 1'b1;
          ex_flush    = 1'b1;
          redir_nx    = 1'b1;
          redir_pc_nx = trap_vec;
          kill_nx     = 1'b1;
          state_nx    = S_TRAP_WAIT;
          cnt_nx      = TRAP_LAT_C;
        end else if (div_done) begin
          state_nx = S_RUN;
        end else if (dcnt == DIV_LAST) begin
          // Pulses land on the edge where dcnt would reach DIV_MAX-1
          pipe_stall = 1'b1;
          kill_nx    = 1'b1;
          tmo_nx     = 1'b1;
          state_nx   = S_RUN;
        end else begin
          pipe_stall = 1'b1;
          if (dcnt != DCNT_SAT) begin
            dcnt_nx = dcnt + DCNT_W'(1);
          end
        end
      end

      default: begin
        state_nx = S_RUN;
        cnt_nx   = '0;
        dcnt_nx  = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed self-checking bench for pipe_ctrl (XLEN=32, TRAP_LAT=2, DIV_MAX=40).
module tb_pipe_ctrl;

  localparam int unsigned XLEN = 32;

  logic            clk;
  logic            rst_n;
  logic            trap_req;
  logic [XLEN-1:0] trap_vec;
  logic            mret_req;
  logic [XLEN-1:0] mepc;
  logic            ex_bj_flag;
  logic [XLEN-1:0] ex_bj_addr;
  logic            ex_div_start;
  logic            div_done;
  logic            ex_is_load;
  logic [4:0]      ex_rd;
  logic [4:0]      id_rs1;
  logic [4:0]      id_rs2;
  logic            id_rs1_used;
  logic            id_rs2_used;
  logic            pipe_stall;
  logic            if_flush;
  logic            id_flush;
  logic            ex_flush;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            div_kill;
  logic            div_timeout;
  logic [1:0]      ctrl_state;

  int n_tests;
  int n_fail;
  int stall_cnt;

  pipe_ctrl #(.XLEN(XLEN), .TRAP_LAT(2), .DIV_MAX(40)) dut (
    .clk(clk), .rst_n(rst_n),
    .trap_req(trap_req), .trap_vec(trap_vec),
    .mret_req(mret_req), .mepc(mepc),
    .ex_bj_flag(ex_bj_flag), .ex_bj_addr(ex_bj_addr),
    .ex_div_start(ex_div_start), .div_done(div_done),
    .ex_is_load(ex_is_load), .ex_rd(ex_rd),
    .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
    .pipe_stall(pipe_stall), .if_flush(if_flush), .id_flush(id_flush),
    .ex_flush(ex_flush), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .div_kill(div_kill),
    .div_timeout(div_timeout), .ctrl_state(ctrl_state)
  );

  // 10 ns clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance past the next rising edge; inputs are then driven mid-cycle
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Let combinational outputs settle before sampling, away from the edge
  task automatic settle();
    #3;
  endtask

  task automatic clear_inputs();
    trap_req = 1'b0; trap_vec = '0; mret_req = 1'b0; mepc = '0;
    ex_bj_flag = 1'b0; ex_bj_addr = '0; ex_div_start = 1'b0; div_done = 1'b0;
    ex_is_load = 1'b0; ex_rd = '0; id_rs1 = '0; id_rs2 = '0;
    id_rs1_used = 1'b0; id_rs2_used = 1'b0;
  endtask

  task automatic check_flush(input string tag, input logic fi, input logic fd, input logic fe);
    check({tag, ".if_flush"}, 64'(if_flush), 64'(fi));
    check({tag, ".id_flush"}, 64'(id_flush), 64'(fd));
    check({tag, ".ex_flush"}, 64'(ex_flush), 64'(fe));
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    clear_inputs();
    rst_n = 1'b0;
    cyc(); cyc();

    // Reset state
    settle();
    check("rst.state", 64'(ctrl_state), 64'd0);
    check("rst.redir_v", 64'(redirect_valid), 64'd0);
    check("rst.redir_pc", 64'(redirect_pc), 64'd0);
    check("rst.kill", 64'(div_kill), 64'd0);
    check("rst.tmo", 64'(div_timeout), 64'd0);
    check("rst.stall", 64'(pipe_stall), 64'd0);
    check_flush("rst", 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
    cyc();

    // Load-use via rs2
    ex_is_load = 1'b1; ex_rd = 5'd5; id_rs2 = 5'd5; id_rs2_used = 1'b1;
    settle();
    check("luh.stall", 64'(pipe_stall), 64'd1);
    check_flush("luh", 1'b0, 1'b1, 1'b0);
    check("luh.state", 64'(ctrl_state), 64'd0);
    cyc();
    clear_inputs();
    settle();
    check("luh_after.stall", 64'(pipe_stall), 64'd0);
    check("luh_after.id_flush", 64'(id_flush), 64'd0);
    check("luh_after.state", 64'(ctrl_state), 64'd0);
    // x0 destination never hazards
    ex_is_load = 1'b1; ex_rd = 5'd0; id_rs1 = 5'd0; id_rs1_used = 1'b1;
    settle();
    check("luh_x0.stall", 64'(pipe_stall), 64'd0);
    // Matching but unused source does not hazard
    ex_rd = 5'd7; id_rs1 = 5'd7; id_rs1_used = 1'b0;
    settle();
    check("luh_unused.stall", 64'(pipe_stall), 64'd0);
    // Matching used rs1 does
    id_rs1_used = 1'b1;
    settle();
    check("luh_rs1.stall", 64'(pipe_stall), 64'd1);
    cyc();
    clear_inputs();

    // Branch redirect
    ex_bj_flag = 1'b1; ex_bj_addr = 32'h8000_0040;
    settle();
    check_flush("bj", 1'b1, 1'b1, 1'b0);
    check("bj.redir_v0", 64'(redirect_valid), 64'd0);
    cyc();
    clear_inputs();
    settle();
    check("bj.redir_v1", 64'(redirect_valid), 64'd1);
    check("bj.redir_pc", 64'(redirect_pc), 64'h8000_0040);
    check("bj.if_flush1", 64'(if_flush), 64'd0);
    cyc();
    settle();
    check("bj.redir_v2", 64'(redirect_valid), 64'd0);

    // mret beats branch in the same cycle
    mret_req = 1'b1; mepc = 32'h0000_1234; ex_bj_flag = 1'b1; ex_bj_addr = 32'h0000_5678;
    settle();
    check_flush("mret", 1'b1, 1'b1, 1'b0);
    cyc();
    clear_inputs();
    settle();
    check("mret.redir_v", 64'(redirect_valid), 64'd1);
    check("mret.redir_pc", 64'(redirect_pc), 64'h0000_1234);
    check("mret.state", 64'(ctrl_state), 64'd0);
    cyc();

    // Trap beats branch; TRAP_LAT=2 settle bubbles; branch ignored while waiting
    trap_req = 1'b1; trap_vec = 32'h0000_0100; ex_bj_flag = 1'b1; ex_bj_addr = 32'h0000_9999;
    settle();
    check_flush("trap", 1'b1, 1'b1, 1'b1);
    cyc();
    clear_inputs();
    settle();
    check("trap.redir_v", 64'(redirect_valid), 64'd1);
    check("trap.redir_pc", 64'(redirect_pc), 64'h0000_0100);
    check("trap.state1", 64'(ctrl_state), 64'd1);
    check("trap.stall1", 64'(pipe_stall), 64'd1);
    cyc();
    ex_bj_flag = 1'b1; ex_bj_addr = 32'h0000_4444;
    settle();
    check("trap.redir_v2", 64'(redirect_valid), 64'd0);
    check("trap.state2", 64'(ctrl_state), 64'd1);
    check("trap.stall2", 64'(pipe_stall), 64'd1);
    check_flush("trap_bj_ign", 1'b0, 1'b0, 1'b0);
    cyc();
    clear_inputs();
    settle();
    check("trap.state3", 64'(ctrl_state), 64'd0);
    check("trap.stall3", 64'(pipe_stall), 64'd0);
    check("trap.redir_v3", 64'(redirect_valid), 64'd0);
    cyc();

    // Nested trap in TRAP_WAIT re-redirects and reloads the settle count
    trap_req = 1'b1; trap_vec = 32'h0000_0100;
    settle();
    cyc();
    trap_req = 1'b1; trap_vec = 32'h0000_0300;
    settle();
    check("nest.redir_pc1", 64'(redirect_pc), 64'h0000_0100);
    check_flush("nest", 1'b1, 1'b1, 1'b1);
    cyc();
    clear_inputs();
    settle();
    check("nest.redir_v", 64'(redirect_valid), 64'd1);
    check("nest.redir_pc2", 64'(redirect_pc), 64'h0000_0300);
    check("nest.stall_a", 64'(pipe_stall), 64'd1);
    cyc();
    settle();
    check("nest.stall_b", 64'(pipe_stall), 64'd1);
    check("nest.state_b", 64'(ctrl_state), 64'd1);
    cyc();
    settle();
    check("nest.state_c", 64'(ctrl_state), 64'd0);
    check("nest.stall_c", 64'(pipe_stall), 64'd0);
    cyc();

    // Divide with div_done 11 cycles after start: stall cycles start..start+10
    stall_cnt = 0;
    ex_div_start = 1'b1;
    settle();
    check("div.stall0", 64'(pipe_stall), 64'd1);
    check("div.state0", 64'(ctrl_state), 64'd0);
    if (pipe_stall === 1'b1) stall_cnt++;
    cyc();
    clear_inputs();
    for (int k = 1; k <= 10; k++) begin
      if (k == 4) begin
        ex_bj_flag = 1'b1; ex_bj_addr = 32'h0000_7777;
      end else begin
        ex_bj_flag = 1'b0;
      end
      settle();
      check("div.state_busy", 64'(ctrl_state), 64'd2);
      check("div.bj_ignored", 64'(if_flush), 64'd0);
      if (pipe_stall === 1'b1) stall_cnt++;
      cyc();
    end
    clear_inputs();
    div_done = 1'b1;
    settle();
    check("div.done_stall", 64'(pipe_stall), 64'd0);
    check("div.done_state", 64'(ctrl_state), 64'd2);
    check("div.stall_cycles", 64'(stall_cnt), 64'd11);
    cyc();
    clear_inputs();
    settle();
    check("div.after_state", 64'(ctrl_state), 64'd0);
    check("div.after_stall", 64'(pipe_stall), 64'd0);
    check("div.after_redir", 64'(redirect_valid), 64'd0);

    // Divide timeout: pulses land 39 cycles after the first DIV_BUSY cycle
    ex_div_start = 1'b1;
    settle();
    cyc();
    clear_inputs();
    for (int k = 0; k < 39; k++) begin
      settle();
      check("tmo.busy_state", 64'(ctrl_state), 64'd2);
      check("tmo.busy_stall", 64'(pipe_stall), 64'd1);
      check("tmo.early_pulse", 64'(div_timeout), 64'd0);
      cyc();
    end
    settle();
    check("tmo.pulse", 64'(div_timeout), 64'd1);
    check("tmo.kill", 64'(div_kill), 64'd1);
    check("tmo.state", 64'(ctrl_state), 64'd0);
    check("tmo.stall", 64'(pipe_stall), 64'd0);
    cyc();
    settle();
    check("tmo.pulse_end", 64'(div_timeout), 64'd0);
    check("tmo.kill_end", 64'(div_kill), 64'd0);
    cyc();

    // Interrupt at DIV_BUSY cycle 5 (with div_done), then reset during TRAP_WAIT
    ex_div_start = 1'b1;
    settle();
    cyc();
    clear_inputs();
    for (int k = 0; k < 5; k++) begin
      cyc();
    end
    trap_req = 1'b1; trap_vec = 32'h0000_0200; div_done = 1'b1;
    settle();
    check("irq.state", 64'(ctrl_state), 64'd2);
    check_flush("irq", 1'b1, 1'b1, 1'b1);
    cyc();
    clear_inputs();
    settle();
    check("irq.kill", 64'(div_kill), 64'd1);
    check("irq.tmo", 64'(div_timeout), 64'd0);
    check("irq.redir_v", 64'(redirect_valid), 64'd1);
    check("irq.redir_pc", 64'(redirect_pc), 64'h0000_0200);
    check("irq.state_tw", 64'(ctrl_state), 64'd1);
    rst_n = 1'b0;
    cyc();
    settle();
    check("rst2.state", 64'(ctrl_state), 64'd0);
    check("rst2.redir_v", 64'(redirect_valid), 64'd0);
    check("rst2.redir_pc", 64'(redirect_pc), 64'd0);
    check("rst2.stall", 64'(pipe_stall), 64'd0);
    check("rst2.kill", 64'(div_kill), 64'd0);
    rst_n = 1'b1;
    cyc();
    settle();
    check("rst2.run_state", 64'(ctrl_state), 64'd0);
    check("rst2.run_stall", 64'(pipe_stall), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
